// File: rtl/dn_port_arbiter.sv
// Arbitrates the williams2 download write port between the HPS ROM stream and
// the high-score restore engine, and sequences game_reset around downloads.
// Optional download byte counter: define DN_ARB_BYTECOUNT_EN.
module dn_port_arbiter #(
    parameter int unsigned AW          = 19,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          hs_req,
    input  logic          hs_wr,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_data,
    output logic          hs_gnt,
    output logic          hs_abort,
    output logic          dn_wr,
    output logic [AW-1:0] dn_addr,
    output logic [7:0]    dn_data,
    output logic          game_reset,
    output logic          dl_done,
    output logic [19:0]   dl_bytes
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DL   = 2'd1,
        S_HOLD = 2'd2,
        S_HS   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_next;
    logic          w_dl_pass;
    logic          w_hs_pass;

    logic          r_hs_gnt;
    logic          r_hs_abort;
    logic          r_dn_wr;
    logic [AW-1:0] r_dn_addr;
    logic [7:0]    r_dn_data;
    logic          r_game_reset;
    logic          r_dl_done;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (dl_active)   w_next = S_DL;
                else if (hs_req) w_next = S_HS;
            end
            S_DL: begin
                if (!dl_active) begin
                    w_next     = S_HOLD;
                    w_cnt_next = HOLD_INIT;
                end
            end
            S_HOLD: begin
                if (dl_active)       w_next = S_DL;
                else if (r_cnt == '0) w_next = S_IDLE;
                else                  w_cnt_next = r_cnt - 8'd1;
            end
            S_HS: begin
                if (dl_active)   w_next = S_DL;
                else if (!hs_req) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A high-score strobe colliding with a download request is discarded.
    assign w_dl_pass = (r_state == S_DL) && dl_wr;
    assign w_hs_pass = (r_state == S_HS) && !dl_active && hs_wr;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hs_gnt     <= 1'b0;
            r_hs_abort   <= 1'b0;
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_game_reset <= 1'b1;
            r_dl_done    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_dn_wr      <= w_dl_pass || w_hs_pass;
            if (w_dl_pass) begin
                r_dn_addr <= dl_addr;
                r_dn_data <= dl_data;
            end else if (w_hs_pass) begin
                r_dn_addr <= hs_addr;
                r_dn_data <= hs_data;
            end
            r_hs_gnt     <= (w_next == S_HS);
            r_hs_abort   <= (r_state == S_HS) && dl_active;
            r_game_reset <= (w_next == S_DL) || (w_next == S_HOLD);
            // Registered one cycle early so the pulse lines up with the last HOLD cycle.
            r_dl_done    <= (w_next == S_HOLD) && (w_cnt_next == '0);
        end
    end

`ifdef DN_ARB_BYTECOUNT_EN
    logic [19:0] r_bytes;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bytes <= '0;
        end else if ((r_state == S_IDLE || r_state == S_HS) && w_next == S_DL) begin
            r_bytes <= '0;
        end else if (w_dl_pass && r_bytes != '1) begin
            r_bytes <= r_bytes + 20'd1;
        end
    end

    assign dl_bytes = r_bytes;
`else
    assign dl_bytes = '0;
`endif

    assign hs_gnt     = r_hs_gnt;
    assign hs_abort   = r_hs_abort;
    assign dn_wr      = r_dn_wr;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign game_reset = r_game_reset;
    assign dl_done    = r_dl_done;

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Directed bench for dn_port_arbiter: downloads, high-score grants, aborts,
// HOLD re-entry and mid-download reset, with hand-computed expectations.
module tb_dn_port_arbiter;

    localparam int unsigned AW = 19;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          hs_req;
    logic          hs_wr;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_data;
    logic          hs_gnt;
    logic          hs_abort;
    logic          dn_wr;
    logic [AW-1:0] dn_addr;
    logic [7:0]    dn_data;
    logic          game_reset;
    logic          dl_done;
    logic [19:0]   dl_bytes;

    int unsigned total = 0;
    int unsigned bad   = 0;

    dn_port_arbiter #(.AW(AW), .HOLD_CYCLES(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .hs_req    (hs_req),
        .hs_wr     (hs_wr),
        .hs_addr   (hs_addr),
        .hs_data   (hs_data),
        .hs_gnt    (hs_gnt),
        .hs_abort  (hs_abort),
        .dn_wr     (dn_wr),
        .dn_addr   (dn_addr),
        .dn_data   (dn_data),
        .game_reset(game_reset),
        .dl_done   (dl_done),
        .dl_bytes  (dl_bytes)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_exp(input int unsigned n);
`ifdef DN_ARB_BYTECOUNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    logic [7:0] tbl [4];
    int unsigned done_cnt;

    initial begin
        tbl[0] = 8'hA5; tbl[1] = 8'h5A; tbl[2] = 8'hFF; tbl[3] = 8'h00;
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        hs_req = 1'b0; hs_wr = 1'b0; hs_addr = '0; hs_data = '0;

        // Reset state
        step(); step();
        chk("rst_game_reset", 32'(game_reset), 32'd1);
        chk("rst_dn_wr",      32'(dn_wr), 32'd0);
        chk("rst_dn_addr",    32'(dn_addr), 32'd0);
        chk("rst_dn_data",    32'(dn_data), 32'd0);
        chk("rst_hs_gnt",     32'(hs_gnt), 32'd0);
        chk("rst_hs_abort",   32'(hs_abort), 32'd0);
        chk("rst_dl_done",    32'(dl_done), 32'd0);
        chk("rst_dl_bytes",   32'(dl_bytes), 32'd0);
        reset = 1'b0;
        chk("post_rst_first_cycle_game_reset", 32'(game_reset), 32'd1);
        step();
        chk("idle_game_reset", 32'(game_reset), 32'd0);

        // Four-byte download
        dl_active = 1'b1;
        step();
        chk("dl_entry_game_reset", 32'(game_reset), 32'd1);
        chk("dl_entry_dn_wr", 32'(dn_wr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dl_wr = 1'b1; dl_addr = AW'(i); dl_data = tbl[i];
            step();
            chk("dl_dn_wr",   32'(dn_wr), 32'd1);
            chk("dl_dn_addr", 32'(dn_addr), 32'(i));
            chk("dl_dn_data", 32'(dn_data), 32'(tbl[i]));
        end
        dl_wr = 1'b0; dl_addr = 19'h7FFFF; dl_data = 8'h33;
        step();
        chk("dl_gap_dn_wr",   32'(dn_wr), 32'd0);
        chk("dl_hold_addr",   32'(dn_addr), 32'd3);
        chk("dl_hold_data",   32'(dn_data), 32'h00);
        dl_active = 1'b0;
        step();
        done_cnt = 0;
        for (int j = 0; j <= 16; j++) begin
            chk("hold_game_reset", 32'(game_reset), (j == 16) ? 32'd0 : 32'd1);
            chk("hold_dl_done", 32'(dl_done), (j == 15) ? 32'd1 : 32'd0);
            if (dl_done) done_cnt++;
            if (j < 16) step();
        end
        chk("dl_done_count", 32'(done_cnt), 32'd1);
        chk("dl_bytes_4", 32'(dl_bytes), bytes_exp(4));

        // High-score grant with three writes
        hs_req = 1'b1;
        step();
        chk("hs_gnt_rise", 32'(hs_gnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            hs_wr = 1'b1; hs_addr = AW'(32'h1000 + i); hs_data = 8'(8'h10 + i);
            step();
            chk("hs_dn_wr",   32'(dn_wr), 32'd1);
            chk("hs_dn_addr", 32'(dn_addr), 32'h1000 + 32'(i));
            chk("hs_dn_data", 32'(dn_data), 32'h10 + 32'(i));
            chk("hs_game_reset", 32'(game_reset), 32'd0);
        end
        hs_wr = 1'b0; hs_req = 1'b0;
        step();
        chk("hs_gnt_fall", 32'(hs_gnt), 32'd0);
        chk("hs_end_dn_wr", 32'(dn_wr), 32'd0);
        hs_wr = 1'b1; hs_addr = 19'h0ABC;
        step();
        chk("hs_wr_idle_dropped", 32'(dn_wr), 32'd0);
        hs_wr = 1'b0;

        // Download preempts high-score grant
        hs_req = 1'b1;
        step();
        hs_wr = 1'b1; hs_addr = 19'h2000; hs_data = 8'h77;
        step();
        chk("pre_abort_dn_wr", 32'(dn_wr), 32'd1);
        hs_addr = 19'h2001; hs_data = 8'h88; dl_active = 1'b1;
        step();
        chk("abort_dn_wr",      32'(dn_wr), 32'd0);
        chk("abort_dn_addr",    32'(dn_addr), 32'h2000);
        chk("abort_pulse",      32'(hs_abort), 32'd1);
        chk("abort_hs_gnt",     32'(hs_gnt), 32'd0);
        chk("abort_game_reset", 32'(game_reset), 32'd1);
        chk("abort_bytes_clr",  32'(dl_bytes), 32'd0);
        hs_wr = 1'b0; hs_req = 1'b0;
        step();
        chk("abort_one_cycle", 32'(hs_abort), 32'd0);
        dl_active = 1'b0;
        for (int j = 0; j < 17; j++) step();
        chk("abort_hold_over_game_reset", 32'(game_reset), 32'd0);
        chk("abort_hold_over_hs_gnt", 32'(hs_gnt), 32'd0);

        // dl_active and hs_req rise together
        dl_active = 1'b1; hs_req = 1'b1;
        step();
        chk("simul_game_reset", 32'(game_reset), 32'd1);
        chk("simul_hs_gnt", 32'(hs_gnt), 32'd0);
        dl_wr = 1'b1; dl_addr = 19'h00042; dl_data = 8'hC3;
        step();
        chk("simul_dn_addr", 32'(dn_addr), 32'h42);
        dl_wr = 1'b0; dl_active = 1'b0;
        step();
        for (int j = 0; j <= 17; j++) begin
            if (j <= 16) chk("simul_hold_hs_gnt", 32'(hs_gnt), 32'd0);
            if (j == 16) chk("simul_hold_end_game_reset", 32'(game_reset), 32'd0);
            if (j == 17) chk("simul_hs_after_hold", 32'(hs_gnt), 32'd1);
            if (j < 17) step();
        end
        chk("simul_bytes", 32'(dl_bytes), bytes_exp(1));
        hs_req = 1'b0;
        step();
        chk("simul_hs_release", 32'(hs_gnt), 32'd0);

        // dl_active re-asserts at HOLD count 5
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            dl_wr = 1'b1; dl_addr = AW'(i + 8); dl_data = 8'(i);
            step();
        end
        dl_wr = 1'b0;
        step();
        chk("reentry_bytes_clr", 32'(dl_bytes), bytes_exp(2));
        dl_active = 1'b0;
        step();
        for (int j = 0; j < 10; j++) begin
            chk("reentry_hold_done", 32'(dl_done), 32'd0);
            step();
        end
        dl_active = 1'b1;
        step();
        chk("reentry_game_reset", 32'(game_reset), 32'd1);
        chk("reentry_no_done", 32'(dl_done), 32'd0);
        dl_wr = 1'b1; dl_addr = 19'h00100; dl_data = 8'hEE;
        step();
        chk("reentry_dn_wr", 32'(dn_wr), 32'd1);
        chk("reentry_bytes_continue", 32'(dl_bytes), bytes_exp(3));
        dl_wr = 1'b0; dl_active = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 18; j++) begin
            step();
            if (dl_done) done_cnt++;
        end
        chk("reentry_done_count", 32'(done_cnt), 32'd1);
        chk("reentry_idle_game_reset", 32'(game_reset), 32'd0);

        // Reset pulsed mid-download
        dl_active = 1'b1;
        step();
        dl_wr = 1'b1; dl_addr = 19'h00055; dl_data = 8'h99;
        step();
        chk("mid_dn_wr", 32'(dn_wr), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_dn_wr",      32'(dn_wr), 32'd0);
        chk("mid_rst_dn_addr",    32'(dn_addr), 32'd0);
        chk("mid_rst_dn_data",    32'(dn_data), 32'd0);
        chk("mid_rst_game_reset", 32'(game_reset), 32'd1);
        chk("mid_rst_bytes",      32'(dl_bytes), 32'd0);
        dl_wr = 1'b0; dl_active = 1'b0; reset = 1'b0;
        step();
        chk("mid_rst_idle_game_reset", 32'(game_reset), 32'd0);
        done_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            if (dl_done) done_cnt++;
            step();
        end
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        chk("mid_rst_hs_abort", 32'(hs_abort), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dn_port_arbiter.md
# dn_port_arbiter

Owns the single game download write port (`dn_addr`/`dn_data`/`dn_wr`) into `williams2` and shares it between two requesters: the HPS ROM download stream and a high-score restore engine. It sequences the game reset around downloads: reset is held for the whole download plus a fixed settle period. The high-score engine is granted the port only while no download is running or settling. It sits in `emu` between `hps_io` and `williams2`, replacing the direct `ioctl_*` to `dn_*` wiring.

## Interface
Parameters:
- `AW`, 19: address width of both requesters and of `dn_addr`.
- `HOLD_CYCLES`, 16: `clk_sys` cycles that `game_reset` stays high after `dl_active` falls; legal range 1..255.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high; the only reset.
- `dl_active`  in  1  download in progress (from `ioctl_download`).
- `dl_wr`  in  1  download byte strobe, one cycle.
- `dl_addr`  in  AW  download byte address.
- `dl_data`  in  8  download byte.
- `hs_req`  in  1  high-score engine requests the port (level).
- `hs_wr`  in  1  high-score byte strobe; honoured only while `hs_gnt`=1.
- `hs_addr`  in  AW  high-score byte address.
- `hs_data`  in  8  high-score byte.
- `hs_gnt`  out  1  port granted to the high-score engine.
- `hs_abort`  out  1  one-cycle pulse: grant revoked by a download.
- `dn_wr`  out  1  write strobe to the game.
- `dn_addr`  out  AW  write address to the game.
- `dn_data`  out  8  write data to the game.
- `game_reset`  out  1  reset to `williams2`.
- `dl_done`  out  1  one-cycle pulse when HOLD expires.
- `dl_bytes`  out  20  count of download bytes written (see Configuration).

## Operation
- FSM states: IDLE, DL, HOLD, HS.
  - IDLE: if `dl_active` go DL; else if `hs_req` go HS.
  - DL: pass `dl_*` through; on `dl_active`=0 load hold counter with HOLD_CYCLES-1 and go HOLD.
  - HOLD: decrement the counter. If `dl_active` rises, go DL. At 0, pulse `dl_done` and go IDLE.
  - HS: `hs_gnt`=1 and `hs_*` passes through. On `hs_req`=0 go IDLE. `dl_active` has priority: on `dl_active`=1 go DL, drop `hs_gnt`, pulse `hs_abort`, and discard any `hs_wr` in that cycle.
- `dl_active` always wins over `hs_req`, including when both rise in the same cycle in IDLE.
- Only the current owner's strobe reaches `dn_wr`.
  - `dl_wr` outside DL is dropped.
  - `hs_wr` outside HS is dropped.
  - In IDLE and HOLD, `dn_wr`=0.
- `dn_addr` and `dn_data` hold their last values when `dn_wr`=0.
- `game_reset` = 1 in DL and HOLD and during `reset`; 0 in IDLE and HS. The high-score engine restores RAM into a running game.
- `dl_bytes` clears on entry to DL from IDLE or HS and does not clear on HOLD→DL. It increments on every passed `dl_wr` and saturates at 0xFFFFF.

## Timing
- All outputs are registered. Pass-through latency is 1 cycle: a strobe at cycle n gives `dn_wr`/`dn_addr`/`dn_data` at n+1.
- `hs_gnt` rises 1 cycle after the IDLE→HS decision, so the earliest accepted `hs_wr` is at the cycle `hs_gnt` is first high.
- `hs_gnt` falls in the same registered update that shows `hs_abort`=1.
- `dl_active` rising at cycle n gives `game_reset`=1 at n+1.
- `dl_active` falling at cycle n gives `game_reset` low at n+1+HOLD_CYCLES, with `dl_done`=1 in the cycle before it falls.
- Reset values: state IDLE; `hs_gnt`=0, `hs_abort`=0, `dn_wr`=0, `dn_addr`=0, `dn_data`=0, `dl_done`=0, `dl_bytes`=0; `game_reset`=1 while `reset` is high, and also in the first cycle after `reset` falls.
- `reset` mid-DL or mid-HS: returns to IDLE immediately; no `hs_abort` or `dl_done` pulse is generated.

## Configuration
- Macro: `DN_ARB_BYTECOUNT_EN`.
- Defined: `dl_bytes` counter is implemented as above.
- Undefined: no counter register is built; `dl_bytes` is tied to 0. All other behaviour is identical.

## Test plan
- Download of 4 bytes (`dl_addr` 0..3, data A5,5A,FF,00) -> `dn_wr` pulses 1 cycle later each with matching addr/data. `game_reset` stays 1 until 16 cycles after `dl_active` falls. `dl_done` pulses once. `dl_bytes`=4.
- `hs_req` in IDLE, 3 writes to 0x1000..0x1002 -> `hs_gnt`=1, three `dn_wr` pulses, `game_reset`=0 throughout. Dropping `hs_req` clears `hs_gnt` next cycle.
- `dl_active` rises while in HS with `hs_wr`=1 the same cycle -> that `hs_wr` is not forwarded. `hs_abort`=1 for one cycle, `hs_gnt`=0, `game_reset`=1.
- `dl_active` and `hs_req` rise together in IDLE -> DL is entered and `hs_gnt` stays 0. After HOLD expires with `hs_req` still 1, HS is entered.
- `dl_active` re-asserts at HOLD count 5 -> back to DL with no `dl_done`. `dl_bytes` continues from its previous value.
- `reset` pulsed mid-download -> outputs return to their reset values and no `dl_done` is pulsed. With `DN_ARB_BYTECOUNT_EN` undefined, `dl_bytes` reads 0 throughout.
